i2c_target_regs: RTL and testbench

//  Soft I2C target (responder) with a byte register bank; the far end of the
//  SB_I2C hard-IP controller. Lets an external I2C controller (or our own SB_I2C
//  via loopback) read/write NUM_REGS bytes that the PicoSoC core also reaches

---
 rtl/i2c_target_regs_pkg.sv | 26 ++
 rtl/i2c_target_regs_if.sv | 25 ++
 rtl/i2c_target_regs_line_filter.sv | 63 ++++++
 rtl/i2c_target_regs.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C target register bank.
//   state_e   : protocol FSM states
//   AckBit    : SDA level meaning ACK on the 9th clock (NackBit the opposite)
//   RwBitPos  : position of the R/W flag inside the address byte
//   RwRead    : R/W flag value that requests a read
package i2c_target_regs_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StWaitStop
  } state_e;

  localparam logic        AckBit   = 1'b0;
  localparam logic        NackBit  = 1'b1;
  localparam int unsigned RwBitPos = 0;
  localparam logic        RwRead   = 1'b1;

endpackage

// File: rtl/i2c_target_regs_if.sv
// CPU memory port (PicoSoC valid/ready style) used to reach the register bank.
//   valid      : request strobe from the CPU
//   ready      : one-cycle completion pulse from the target
//   address    : byte address; register index taken from bits [2 +: log2(regs)]
//   write_data : write data, only [7:0] meaningful
//   wstrb      : wstrb[0]=1 selects a write, otherwise a read
//   read_data  : {24'h0, reg}, valid while ready is high
interface i2c_target_regs_if;
  logic        valid;
  logic        ready;
  logic [23:0] address;
  logic [31:0] write_data;
  logic [3:0]  wstrb;
  logic [31:0] read_data;

  modport master (
    output valid, address, write_data, wstrb,
    input  ready, read_data
  );

  modport slave (
    input  valid, address, write_data, wstrb,
    output ready, read_data
  );
endinterface

// File: rtl/i2c_target_regs_line_filter.sv
// Synchroniser plus glitch filter for one open-drain I2C line.
//   clock   : system clock
//   resetn  : asynchronous active-low reset (line assumed idle-high)
//   line_i  : asynchronous pad input
//   level_o : filtered level, changes only after FilterLen equal samples
//   rise_o  : one-cycle pulse when level_o goes 0->1
//   fall_o  : one-cycle pulse when level_o goes 1->0
module i2c_target_regs_line_filter #(
  parameter int unsigned FilterLen = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int unsigned CntW = (FilterLen > 1) ? $clog2(FilterLen) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d, fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples that disagree with the accepted level
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(FilterLen - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/i2c_target_regs.sv
// Soft I2C target with a byte register bank shared with the CPU memory port.
//   clock   : system clock (>= 16x SCL)
//   resetn  : asynchronous active-low reset
//   scl_i   : SCL pad input
//   sda_i   : SDA pad input
//   sda_oe  : 1 pulls SDA low (open drain)
//   bus     : CPU valid/ready port (slave side)
//   busy    : high from an accepted address match until STOP
//   wr_irq  : one-cycle pulse at STOP after a transfer that wrote data
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_oe,
  i2c_target_regs_if.slave        bus,
  output logic                    busy,
  output logic                    wr_irq
);
  localparam int unsigned IdxW = $clog2(NUM_REGS);
  typedef logic [IdxW-1:0] idx_t;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_target_regs_line_filter #(.FilterLen(FILTER_LEN)) u_scl_filter (
    .clock   (clock),
    .resetn  (resetn),
    .line_i  (scl_i),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_target_regs_line_filter #(.FilterLen(FILTER_LEN)) u_sda_filter (
    .clock   (clock),
    .resetn  (resetn),
    .line_i  (sda_i),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d, tx_q, tx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        ack_seen_q, ack_seen_d, rw_q, rw_d;
  idx_t        ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic        wrote_q, wrote_d, wr_irq_q, wr_irq_d;
  logic        ready_q, ready_d;
  logic [31:0] read_data_q, read_data_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];
  logic        i2c_we;

  logic       start_det, stop_det;
  logic [7:0] rx_byte;
  idx_t       cpu_idx;
  logic       cpu_req;

  assign start_det = sda_fall && scl_lvl;
  assign stop_det  = sda_rise && scl_lvl;
  assign rx_byte   = {shift_q[6:0], sda_lvl};
  assign cpu_idx   = bus.address[2 +: IdxW];
  assign cpu_req   = bus.valid && !ready_q;

  // Protocol FSM. ACK states span from the 8th SCL rise to the 9th SCL fall;
  // ack_seen_q separates the fall that starts the ACK bit from the one ending it.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    ack_seen_d = ack_seen_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wrote_d    = wrote_q;
    wr_irq_d   = 1'b0;
    i2c_we     = 1'b0;
    if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      wrote_d  = 1'b0;
      wr_irq_d = wrote_q;
    end else if (start_det) begin
      state_d    = StAddr;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = 3'd0;
      ack_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_seen_d = 1'b0;
              if (state_q == StAddr) begin
                if (rx_byte[7:1] == TARGET_ADDR) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[RwBitPos];
                end else begin
                  state_d = StWaitStop;
                  busy_d  = 1'b0;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = rx_byte[IdxW-1:0];
                state_d = StPtrAck;
              end else begin
                state_d = StWdataAck;
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_rise) begin
            ack_seen_d = 1'b1;
            if (state_q == StWdataAck) begin
              i2c_we  = 1'b1;
              ptr_d   = ptr_q + idx_t'(1);
              wrote_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (!ack_seen_q) begin
              sda_oe_d = ~AckBit;
            end else begin
              ack_seen_d = 1'b0;
              bit_cnt_d  = 3'd0;
              sda_oe_d   = 1'b0;
              if (state_q == StAddrAck && rw_q == RwRead) begin
                tx_d     = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
                state_d  = StRdata;
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d    = StRdataAck;
              ack_seen_d = 1'b0;
            end
          end else if (scl_fall) begin
            // bit_cnt_q already counts the bits clocked out, so it indexes the next one
            sda_oe_d = ~tx_q[3'd7 - bit_cnt_q];
          end
        end
        StRdataAck: begin
          if (scl_fall && !ack_seen_q) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (sda_lvl == NackBit) begin
              state_d = StWaitStop;
            end else begin
              ack_seen_d = 1'b1;
              ptr_d      = ptr_q + idx_t'(1);
            end
          end else if (scl_fall) begin
            ack_seen_d = 1'b0;
            bit_cnt_d  = 3'd0;
            tx_d       = regs_q[ptr_q];
            sda_oe_d   = ~regs_q[ptr_q][7];
            state_d    = StRdata;
          end
        end
        StIdle, StWaitStop: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Register bank: the I2C write is applied last so it wins a same-register collision.
  always_comb begin
    regs_d      = regs_q;
    ready_d     = cpu_req;
    read_data_d = read_data_q;
    if (cpu_req) begin
      read_data_d = {24'h0, regs_q[cpu_idx]};
      if (bus.wstrb[0]) begin
        regs_d[cpu_idx] = bus.write_data[7:0];
      end
    end
    if (i2c_we) begin
      regs_d[ptr_q] = shift_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      ack_seen_q  <= 1'b0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wrote_q     <= 1'b0;
      wr_irq_q    <= 1'b0;
      ready_q     <= 1'b0;
      read_data_q <= 32'h0;
      regs_q      <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_seen_q  <= ack_seen_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wrote_q     <= wrote_d;
      wr_irq_q    <= wr_irq_d;
      ready_q     <= ready_d;
      read_data_q <= read_data_d;
      regs_q      <= regs_d;
    end
  end

  assign sda_oe        = sda_oe_q;
  assign busy          = busy_q;
  assign wr_irq        = wr_irq_q;
  assign bus.ready     = ready_q;
  assign bus.read_data = read_data_q;

  logic unused_bus;
  assign unused_bus = ^{bus.address, bus.write_data[31:8], bus.wstrb[3:1]};
endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: table-driven CPU port vectors, then
// bit-banged I2C transactions covering write, read with wrap, wrong address,
// glitches, mid-byte reset and same-cycle CPU/I2C collisions.
module tb_i2c_target_regs;
  localparam int Q = 10;  // clocks per quarter SCL period

  logic clock = 1'b0;
  logic resetn;
  logic scl_m, sda_m, sda_line;
  logic sda_oe, busy, wr_irq;
  int   total = 0;
  int   bad = 0;
  int   irq_cnt = 0;

  i2c_target_regs_if bus_if();

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_regs #(
    .TARGET_ADDR (7'h42),
    .NUM_REGS    (8),
    .FILTER_LEN  (3)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .scl_i  (scl_m),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .bus    (bus_if),
    .busy   (busy),
    .wr_irq (wr_irq)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (wr_irq) irq_cnt <= irq_cnt + 1;

  typedef struct {
    logic [3:0]  wstrb;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } cpu_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cpu_chk(input string name, input logic [3:0] ws, input logic [23:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
    logic r1, r2;
    logic [31:0] rd;
    bus_if.valid = 1'b1; bus_if.address = a; bus_if.write_data = d; bus_if.wstrb = ws;
    clks(1);
    r1 = bus_if.ready; rd = bus_if.read_data;
    bus_if.valid = 1'b0;
    clks(1);
    r2 = bus_if.ready;
    chk({name, " rdata"}, rd, exp);
    chk({name, " ready pulse"}, {30'd0, r1, r2}, 32'd2);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b1; clks(Q);
  endtask

  task automatic wbit(input logic b);
    sda_m = b; clks(Q);
    scl_m = 1'b1; clks(2 * Q);
    scl_m = 1'b0; clks(Q);
  endtask

  // Same bit with one-clock runts on SCL (both phases) and on SDA while SCL is high
  task automatic wbit_glitch(input logic b);
    sda_m = b; clks(Q / 2);
    scl_m = 1'b1; clks(1); scl_m = 1'b0;
    clks(Q - Q / 2 - 1);
    scl_m = 1'b1; clks(Q);
    sda_m = ~b; clks(1); sda_m = b;
    clks(Q / 2 - 1);
    scl_m = 1'b0; clks(1); scl_m = 1'b1;
    clks(Q - Q / 2 - 1);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    b = sda_line; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit glitch, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      if (glitch) wbit_glitch(v[i]);
      else wbit(v[i]);
    end
    rbit(b);
    acked = ~b;
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      v[i] = b;
    end
    wbit(ack ? 1'b0 : 1'b1);
  endtask

  // Data byte whose ACK-bit SCL rise reaches the FSM on the same clock edge as a CPU write
  task automatic send_byte_collide(input logic [7:0] v, input logic [23:0] ca,
                                   input logic [31:0] cd, output logic acked,
                                   output logic [31:0] rd, output logic [1:0] rdy);
    for (int i = 7; i >= 0; i--) wbit(v[i]);
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(5);  // 2 sync flops + 3 filter samples, FSM acts on the 6th edge
    bus_if.valid = 1'b1; bus_if.address = ca; bus_if.write_data = cd; bus_if.wstrb = 4'b0001;
    clks(1);
    rdy[1] = bus_if.ready; rd = bus_if.read_data;
    bus_if.valid = 1'b0;
    clks(1);
    rdy[0] = bus_if.ready;
    acked = ~sda_line;
    clks(2 * Q - 7);
    scl_m = 1'b0; clks(Q);
  endtask

  cpu_vec_t   vecs [8];
  logic       ack;
  logic [7:0] v;
  logic [31:0] rd;
  logic [1:0] rdy;
  int         irq0;

  initial begin
    vecs[0] = '{4'b0001, 24'h000000, 32'h000000DE, 32'h00000000};
    vecs[1] = '{4'b0000, 24'h000000, 32'h00000000, 32'h000000DE};
    vecs[2] = '{4'b0001, 24'h000005, 32'h123456AB, 32'h00000000};
    vecs[3] = '{4'b0000, 24'h000024, 32'h00000000, 32'h000000AB};
    vecs[4] = '{4'b1111, 24'hFFFF1C, 32'h000000C3, 32'h00000000};
    vecs[5] = '{4'b1110, 24'h00001C, 32'h000000FF, 32'h000000C3};
    vecs[6] = '{4'b0000, 24'h00001C, 32'h00000000, 32'h000000C3};
    vecs[7] = '{4'b0001, 24'h000000, 32'h00000000, 32'h000000DE};

    resetn = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    bus_if.valid = 1'b0; bus_if.address = '0; bus_if.write_data = '0; bus_if.wstrb = '0;
    clks(3);
    chk("reset sda_oe", sda_oe, 0);
    chk("reset ready", bus_if.ready, 0);
    chk("reset read_data", bus_if.read_data, 0);
    chk("reset busy", busy, 0);
    chk("reset wr_irq", wr_irq, 0);
    resetn = 1'b1;
    clks(20);

    for (int i = 0; i < 8; i++) begin
      cpu_chk($sformatf("vec%0d", i), vecs[i].wstrb, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rd);
    end

    resetn = 1'b0; clks(2); resetn = 1'b1; clks(20);
    cpu_chk("regs cleared", 4'b0000, 24'h04, 0, 32'h0);

    // 1: write two bytes from pointer 3
    irq0 = irq_cnt;
    i2c_start();
    send_byte(8'h84, 0, ack); chk("t1 addr ack", ack, 1);
    chk("t1 busy", busy, 1);
    send_byte(8'h03, 0, ack); chk("t1 ptr ack", ack, 1);
    send_byte(8'hA5, 0, ack); chk("t1 d0 ack", ack, 1);
    send_byte(8'h5A, 0, ack); chk("t1 d1 ack", ack, 1);
    i2c_stop(); clks(4);
    chk("t1 busy after stop", busy, 0);
    chk("t1 wr_irq pulses", irq_cnt - irq0, 1);
    cpu_chk("t1 reg3", 4'b0000, 24'h0C, 0, 32'h000000A5);
    cpu_chk("t1 reg4", 4'b0000, 24'h10, 0, 32'h0000005A);

    // 2: read with pointer wrap, repeated START
    irq0 = irq_cnt;
    cpu_chk("t2 w6", 4'b0001, 24'h18, 32'h11, 32'h0);
    cpu_chk("t2 w7", 4'b0001, 24'h1C, 32'h22, 32'h0);
    cpu_chk("t2 w0", 4'b0001, 24'h00, 32'h33, 32'h0);
    i2c_start();
    send_byte(8'h84, 0, ack); chk("t2 addr ack", ack, 1);
    send_byte(8'h06, 0, ack); chk("t2 ptr ack", ack, 1);
    i2c_start();
    send_byte(8'h85, 0, ack); chk("t2 raddr ack", ack, 1);
    read_byte(1, v); chk("t2 rd0", v, 8'h11);
    read_byte(1, v); chk("t2 rd1", v, 8'h22);
    read_byte(0, v); chk("t2 rd2 wrap", v, 8'h33);
    chk("t2 sda released", sda_oe, 0);
    chk("t2 busy before stop", busy, 1);
    i2c_stop(); clks(4);
    chk("t2 busy after stop", busy, 0);
    chk("t2 no wr_irq", irq_cnt - irq0, 0);

    // 3: wrong address
    irq0 = irq_cnt;
    i2c_start();
    send_byte(8'h86, 0, ack); chk("t3 addr nack", ack, 0);
    chk("t3 busy", busy, 0);
    send_byte(8'h01, 0, ack); chk("t3 b1 nack", ack, 0);
    send_byte(8'hFF, 0, ack); chk("t3 b2 nack", ack, 0);
    i2c_stop(); clks(4);
    chk("t3 busy after", busy, 0);
    chk("t3 no wr_irq", irq_cnt - irq0, 0);
    cpu_chk("t3 reg1", 4'b0000, 24'h04, 0, 32'h0);
    cpu_chk("t3 reg3", 4'b0000, 24'h0C, 0, 32'hA5);

    // 4: glitches inside a data byte
    irq0 = irq_cnt;
    i2c_start();
    send_byte(8'h84, 0, ack); chk("t4 addr ack", ack, 1);
    send_byte(8'h05, 0, ack); chk("t4 ptr ack", ack, 1);
    send_byte(8'h3C, 1, ack); chk("t4 data ack", ack, 1);
    i2c_stop(); clks(4);
    chk("t4 wr_irq", irq_cnt - irq0, 1);
    cpu_chk("t4 reg5", 4'b0000, 24'h14, 0, 32'h3C);

    // 6: same-cycle collisions
    i2c_start();
    send_byte(8'h84, 0, ack); chk("t6a addr ack", ack, 1);
    send_byte(8'h02, 0, ack); chk("t6a ptr ack", ack, 1);
    send_byte_collide(8'h77, 24'h08, 32'h99, ack, rd, rdy);
    chk("t6a data ack", ack, 1);
    chk("t6a cpu rdata", rd, 32'h0);
    chk("t6a ready pulse", rdy, 2'b10);
    i2c_stop(); clks(4);
    cpu_chk("t6a reg2", 4'b0000, 24'h08, 0, 32'h77);
    cpu_chk("t6b preset reg2", 4'b0001, 24'h08, 32'h01, 32'h77);
    i2c_start();
    send_byte(8'h84, 0, ack); chk("t6b addr ack", ack, 1);
    send_byte(8'h02, 0, ack); chk("t6b ptr ack", ack, 1);
    send_byte_collide(8'h77, 24'h14, 32'h99, ack, rd, rdy);
    chk("t6b data ack", ack, 1);
    chk("t6b cpu rdata", rd, 32'h3C);
    chk("t6b ready pulse", rdy, 2'b10);
    i2c_stop(); clks(4);
    cpu_chk("t6b reg2", 4'b0000, 24'h08, 0, 32'h77);
    cpu_chk("t6b reg5", 4'b0000, 24'h14, 0, 32'h99);

    // 5: reset in the middle of a read byte (reg3 = A5)
    i2c_start();
    send_byte(8'h84, 0, ack); chk("t5 addr ack", ack, 1);
    send_byte(8'h03, 0, ack); chk("t5 ptr ack", ack, 1);
    i2c_start();
    send_byte(8'h85, 0, ack); chk("t5 raddr ack", ack, 1);
    for (int i = 7; i >= 4; i--) begin
      logic b;
      rbit(b);
      v[i] = b;
    end
    chk("t5 first nibble", v[7:4], 4'hA);
    chk("t5 driving bit3", sda_oe, 1);
    #2 resetn = 1'b0;
    #1 chk("t5 sda_oe async", sda_oe, 0);
    chk("t5 busy in reset", busy, 0);
    clks(3);
    scl_m = 1'b1; sda_m = 1'b1;
    clks(2);
    resetn = 1'b1;
    clks(20);
    cpu_chk("t5 reg3 cleared", 4'b0000, 24'h0C, 0, 32'h0);
    irq0 = irq_cnt;
    i2c_start();
    send_byte(8'h84, 0, ack); chk("t5 w addr ack", ack, 1);
    send_byte(8'h07, 0, ack); chk("t5 w ptr ack", ack, 1);
    send_byte(8'hE1, 0, ack); chk("t5 w data ack", ack, 1);
    i2c_stop(); clks(4);
    chk("t5 wr_irq", irq_cnt - irq0, 1);
    cpu_chk("t5 reg7", 4'b0000, 24'h1C, 0, 32'hE1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
